mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port memory interface between the instruction-fetch requester (IF) and the data-memory requester (DM, driven by the mem-stage controls mem_we/mem_read/mem_byte).
- Sequences each access through a req/ack handshake with a variable-latency memory.
- Returns read data to the winning requester.
- Produces the pipeline stall while either requester is waiting.

Parameters:
- STARVE_LIMIT, 4: max consecutive DM grants while IF is pending before IF is forced to win; range 1..15.
- TIMEOUT_CYCLES, 64: cycles in a BUSY state without mem_ack before abort; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  32  fetch address, word aligned
- if_rdata  out  32  fetch data, valid with if_ready
- if_ready  out  1  one-cycle completion pulse to IF
- dm_req  in  1  data request; held until dm_ready
- dm_we  in  1  1 = store, 0 = load
- dm_byte  in  1  byte access
- dm_addr  in  32  data address
- dm_wdata  in  32  store data
- dm_rdata  out  32  load data, valid with dm_ready
- dm_ready  out  1  one-cycle completion pulse to DM
- mem_req  out  1  request to memory
- mem_we  out  1  write enable to memory
- mem_byte  out  1  byte access to memory
- mem_addr  out  32  address to memory
- mem_wdata  out  32  write data to memory
- mem_rdata  in  32  memory read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion from memory
- stall  out  1  pipeline stall
- timeout_err  out  1  present only with ARB_TIMEOUT_EN

Behaviour:
- States: IDLE, BUSY_IF, BUSY_DM, RESP.
- Reset (rst high at an edge): state = IDLE, starve_cnt = 0, resp_sel = IF.
  - All registered outputs are 0: mem_req, mem_we, mem_byte, mem_addr, mem_wdata, if_rdata, dm_rdata, if_ready, dm_ready, timeout_err.
  - rst wins over every other event, including an in-flight access. The access is dropped and no ready pulse is issued.
- IDLE transitions:
  - Only dm_req: go to BUSY_DM.
  - Only if_req: go to BUSY_IF.
  - Both: go to BUSY_DM, unless starve_cnt == STARVE_LIMIT, in which case go to BUSY_IF.
  - Neither: stay in IDLE.
  - Any mem_ack seen in IDLE or RESP is ignored; this covers late acks after a reset.
- Starve counter:
  - Increments on each DM grant made while if_req is high, saturating at STARVE_LIMIT.
  - Clears on any IF grant.
  - Clears on a DM grant made while if_req is low.
- Grant register loads: on the IDLE→BUSY edge, the winner's address, we, byte and wdata are registered onto the mem_* outputs and mem_req goes high.
  - IF grant: mem_we = 0, mem_byte = 0, mem_wdata = 0.
- BUSY_x:
  - mem_req stays high and mem_* stay stable until mem_ack.
  - On mem_ack: mem_req goes to 0 in the next cycle, mem_rdata is captured into x_rdata (0 for a DM store), and the state goes to RESP with resp_sel = x.
- RESP:
  - The selected ready output is high for exactly this cycle; the state then returns to IDLE.
  - The requester drops req in the same cycle.
  - IDLE arbitration in the following cycle sees the updated req values, so there are no duplicate grants.
- Latency: from req sampled in IDLE at cycle 0 with mem_ack at cycle N (N ≥ 1), ready rises at cycle N+1. Minimum is 2 cycles after the request edge; the state is back in IDLE at N+2.
- Rdata hold: if_rdata and dm_rdata hold their value until the next capture.
- Stall: combinational, stall = (if_req & ~if_ready) | (dm_req & ~dm_ready).
- Address width: mem_addr is passed through unmodified. Byte lane selection belongs to the memory.
- Requests changing their address while pending are a protocol violation. The registered copy is used.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - A counter runs in BUSY_x.
  - After TIMEOUT_CYCLES cycles without mem_ack, the arbiter drops mem_req, loads x_rdata = 32'hDEADBEEF and enters RESP.
  - timeout_err is high for the RESP cycle together with the ready pulse.
  - A mem_ack arriving in the same cycle as the timeout wins: normal completion, timeout_err = 0.
- When undefined: no counter and no timeout_err port; BUSY waits for mem_ack indefinitely.

Test Plan:
- IF load, ack 1 cycle later:
  - Stimulus: if_req = 1, if_addr = 0x00400000, mem_rdata = 0x8C020004.
  - Required response: mem_req high one cycle after the request; if_ready pulses one cycle after ack with if_rdata = 0x8C020004; stall high until the pulse.
- Simultaneous requests:
  - Stimulus: if_req and dm_req (load, addr 0x10010000) both rise in the same cycle.
  - Required response: DM is granted first; IF is granted immediately after dm_ready; the two mem_addr values appear in that order.
- Starvation, STARVE_LIMIT = 4:
  - Stimulus: dm_req held continuously, if_req held.
  - Required response: grant order DM, DM, DM, DM, IF, DM...
- Store:
  - Stimulus: dm_we = 1, dm_byte = 1, addr 0x10010003, wdata 0xAB.
  - Required response: mem_we = 1, mem_byte = 1, mem_addr/mem_wdata match the inputs, dm_rdata = 0 at dm_ready.
- Reset mid-access:
  - Stimulus: rst asserted in BUSY_DM; mem_ack arrives 2 cycles after rst is released.
  - Required response: mem_req = 0 after rst; no dm_ready pulse; the late ack is ignored.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8:
  - Stimulus: mem_ack never asserted.
  - Required response: ready plus timeout_err at cycle 9 of BUSY; rdata = 0xDEADBEEF.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction fetch (IF) and data memory (DM) requesters.
// Define ARB_TIMEOUT_EN to add a BUSY watchdog that aborts with 32'hDEADBEEF and pulses timeout_err.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic        dm_byte,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_byte,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall
`ifdef ARB_TIMEOUT_EN
   ,output logic        timeout_err
`endif
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, RESP} state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic       SEL_IF     = 1'b0;
    localparam logic       SEL_DM     = 1'b1;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mem_port_arbiter: STARVE_LIMIT or TIMEOUT_CYCLES out of range");
    end

    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        resp_sel_q, resp_sel_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_byte_q, mem_byte_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmr_q, tmr_d;
    logic          tout_q, tout_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            resp_sel_q  <= SEL_IF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_byte_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
`ifdef ARB_TIMEOUT_EN
            tmr_q       <= '0;
            tout_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            resp_sel_q  <= resp_sel_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_byte_q  <= mem_byte_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
`ifdef ARB_TIMEOUT_EN
            tmr_q       <= tmr_d;
            tout_q      <= tout_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        resp_sel_d  = resp_sel_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_byte_d  = mem_byte_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
`ifdef ARB_TIMEOUT_EN
        tmr_d       = tmr_q;
        tout_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // DM normally wins; IF is forced through once DM has won STARVE_LIMIT times in a row
                if (dm_req && !(if_req && starve_q == STARVE_MAX)) begin
                    state_d     = BUSY_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_byte_d  = dm_byte;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    if (!if_req)
                        starve_d = '0;
                    else if (starve_q != STARVE_MAX)
                        starve_d = starve_q + 4'd1;
`ifdef ARB_TIMEOUT_EN
                    tmr_d = TW'(TIMEOUT_CYCLES - 1);
`endif
                end else if (if_req) begin
                    state_d     = BUSY_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_byte_d  = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    starve_d    = '0;
`ifdef ARB_TIMEOUT_EN
                    tmr_d = TW'(TIMEOUT_CYCLES - 1);
`endif
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (mem_ack) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (state_q == BUSY_IF) begin
                        resp_sel_d = SEL_IF;
                        if_rdata_d = mem_rdata;
                    end else begin
                        resp_sel_d = SEL_DM;
                        dm_rdata_d = mem_we_q ? 32'h0 : mem_rdata;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmr_q == '0) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    tout_d    = 1'b1;
                    if (state_q == BUSY_IF) begin
                        resp_sel_d = SEL_IF;
                        if_rdata_d = 32'hDEADBEEF;
                    end else begin
                        resp_sel_d = SEL_DM;
                        dm_rdata_d = 32'hDEADBEEF;
                    end
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_byte  = mem_byte_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ready  = (state_q == RESP) && (resp_sel_q == SEL_IF);
    assign dm_ready  = (state_q == RESP) && (resp_sel_q == SEL_DM);
    assign stall     = (if_req & ~if_ready) | (dm_req & ~dm_ready);
`ifdef ARB_TIMEOUT_EN
    assign timeout_err = tout_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requesters and a memory responder drive the DUT,
// a negedge monitor pops expected grants and responses. Timeout cases build with ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_ready, dm_req, dm_we, dm_byte, dm_ready;
    logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
    logic        mem_req, mem_we, mem_byte, mem_ack, stall;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef ARB_TIMEOUT_EN
    logic        timeout_err;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_byte(dm_byte), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall)
`ifdef ARB_TIMEOUT_EN
       ,.timeout_err(timeout_err)
`endif
    );

    typedef struct { logic [31:0] addr; logic we; logic byt; logic [31:0] wdata; } req_t;
    typedef struct { logic [31:0] data; logic to; } rsp_t;

    req_t ifq[$], dmq[$], exp_grant[$];
    rsp_t exp_if[$], exp_dm[$];

    int checks = 0, errors = 0;
    int cyc = 0;
    int last_grant_cyc = 0, last_if_ready_cyc = 0, last_dm_ready_cyc = 0;
    int ack_delay = 1;
    bit ack_en = 1'b1;
    int late_req = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: DUT output with nothing expected (t=%0t)", name, $time);
    endtask

    task automatic push_if(input logic [31:0] a, input logic [31:0] d, input logic to);
        ifq.push_back('{a, 1'b0, 1'b0, 32'h0});
        exp_grant.push_back('{a, 1'b0, 1'b0, 32'h0});
        exp_if.push_back('{d, to});
    endtask

    task automatic push_dm(input logic [31:0] a, input logic we, input logic byt,
                           input logic [31:0] wd, input logic [31:0] d, input logic to);
        dmq.push_back('{a, we, byt, wd});
        exp_grant.push_back('{a, we, byt, wd});
        exp_dm.push_back('{d, to});
    endtask

    task automatic drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ifq.size() == 0 && dmq.size() == 0 && !if_req && !dm_req &&
                exp_grant.size() == 0 && exp_if.size() == 0 && exp_dm.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk({name, "_drain"}, 64'(done), 64'd1);
        @(negedge clk);
    endtask

    // memory model: swapped halves of the address, with one fixed fetch word
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a == 32'h0040_0000) ? 32'h8C02_0004 : {a[15:0], a[31:16]};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin : if_requester
        req_t cur;
        if_req = 1'b0; if_addr = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                if_req = 1'b0;
                ifq.delete();
            end else begin
                if (if_req && if_ready) if_req = 1'b0;
                if (!if_req && ifq.size() > 0) begin
                    cur = ifq.pop_front();
                    if_addr = cur.addr;
                    if_req = 1'b1;
                end
            end
        end
    end

    initial begin : dm_requester
        req_t cur;
        dm_req = 1'b0; dm_we = 1'b0; dm_byte = 1'b0; dm_addr = '0; dm_wdata = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                dm_req = 1'b0;
                dmq.delete();
            end else begin
                if (dm_req && dm_ready) dm_req = 1'b0;
                if (!dm_req && dmq.size() > 0) begin
                    cur = dmq.pop_front();
                    dm_addr = cur.addr; dm_we = cur.we; dm_byte = cur.byt; dm_wdata = cur.wdata;
                    dm_req = 1'b1;
                end
            end
        end
    end

    initial begin : responder
        int wcnt = 0;
        int served = 0;
        mem_ack = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (served != late_req) begin
                served++;
                mem_ack = 1'b1;
                mem_rdata = 32'h1234_5678;
            end else if (mem_req && ack_en) begin
                if (wcnt == ack_delay - 1) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_data(mem_addr);
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin : monitor
        logic prev_req = 1'b0;
        req_t g;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (mem_req && !prev_req) begin
                last_grant_cyc = cyc;
                if (exp_grant.size() == 0) unexpected("grant");
                else begin
                    g = exp_grant.pop_front();
                    chk("grant_addr", 64'(mem_addr), 64'(g.addr));
                    chk("grant_we_byte_wdata", 64'({mem_we, mem_byte, mem_wdata}),
                        64'({g.we, g.byt, g.wdata}));
                end
            end
            prev_req = mem_req;
            if (if_ready) begin
                last_if_ready_cyc = cyc;
                if (exp_if.size() == 0) unexpected("if_ready");
                else begin
                    r = exp_if.pop_front();
                    chk("if_rdata", 64'(if_rdata), 64'(r.data));
`ifdef ARB_TIMEOUT_EN
                    chk("if_timeout_err", 64'(timeout_err), 64'(r.to));
`endif
                end
            end
            if (dm_ready) begin
                last_dm_ready_cyc = cyc;
                if (exp_dm.size() == 0) unexpected("dm_ready");
                else begin
                    r = exp_dm.pop_front();
                    chk("dm_rdata", 64'(dm_rdata), 64'(r.data));
`ifdef ARB_TIMEOUT_EN
                    chk("dm_timeout_err", 64'(timeout_err), 64'(r.to));
`endif
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin : main
        logic bad;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_mem", 64'({mem_req, mem_we, mem_byte, mem_addr}), 64'd0);
        chk("reset_wdata", 64'(mem_wdata), 64'd0);
        chk("reset_rdata", {if_rdata, dm_rdata}, 64'd0);
        chk("reset_ready_stall", 64'({if_ready, dm_ready, stall}), 64'd0);
        @(posedge clk); #2 rst = 1'b0;

        // IF fetch, ack one cycle after mem_req
        @(posedge clk); #2;
        ack_delay = 1;
        push_if(32'h0040_0000, 32'h8C02_0004, 1'b0);
        for (int i = 0; i < 20 && !if_req; i++) @(negedge clk);
        chk("t1_req_seen", 64'(if_req), 64'd1);
        chk("t1_c0_stall", 64'(stall), 64'd1);
        chk("t1_c0_mem_req", 64'(mem_req), 64'd0);
        @(negedge clk);
        chk("t1_c1_mem_req", 64'(mem_req), 64'd1);
        chk("t1_c1_stall_ready", 64'({stall, if_ready}), 64'b10);
        @(negedge clk);
        chk("t1_c2_ready_stall", 64'({if_ready, stall}), 64'b10);
        chk("t1_c2_rdata", 64'(if_rdata), 64'h8C02_0004);
        @(negedge clk);
        chk("t1_c3_ready_memreq", 64'({if_ready, mem_req}), 64'b00);
        chk("t1_c3_rdata_hold", 64'(if_rdata), 64'h8C02_0004);
        drain("t1");

        // simultaneous requests: DM first, IF granted right after dm_ready
        ack_delay = 2;
        push_dm(32'h1001_0000, 1'b0, 1'b0, 32'h0, 32'h0000_1001, 1'b0);
        push_if(32'h0040_0010, 32'h0010_0040, 1'b0);
        drain("t2");
        chk("t2_if_grant_gap", 64'(last_grant_cyc - last_dm_ready_cyc), 64'd2);

        // starvation: DM x4, IF, DM, DM, IF
        ack_delay = 1;
        push_dm(32'h1001_0020, 1'b0, 1'b0, 32'h0, 32'h0020_1001, 1'b0);
        push_dm(32'h1001_0024, 1'b0, 1'b0, 32'h0, 32'h0024_1001, 1'b0);
        push_dm(32'h1001_0028, 1'b0, 1'b0, 32'h0, 32'h0028_1001, 1'b0);
        push_dm(32'h1001_002C, 1'b0, 1'b0, 32'h0, 32'h002C_1001, 1'b0);
        push_if(32'h0040_0020, 32'h0020_0040, 1'b0);
        push_dm(32'h1001_0030, 1'b0, 1'b0, 32'h0, 32'h0030_1001, 1'b0);
        push_dm(32'h1001_0034, 1'b0, 1'b0, 32'h0, 32'h0034_1001, 1'b0);
        push_if(32'h0040_0024, 32'h0024_0040, 1'b0);
        drain("t3");

        // byte store: dm_rdata reads back as zero
        ack_delay = 3;
        push_dm(32'h1001_0003, 1'b1, 1'b1, 32'h0000_00AB, 32'h0, 1'b0);
        drain("t4");

        // reset in BUSY_DM, then a late ack
        ack_en = 1'b0;
        dmq.push_back('{32'h1001_0040, 1'b0, 1'b0, 32'h0});
        exp_grant.push_back('{32'h1001_0040, 1'b0, 1'b0, 32'h0});
        for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
        chk("t5_granted", 64'(mem_req), 64'd1);
        @(posedge clk); #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("t5_mem_req_after_rst", 64'(mem_req), 64'd0);
        @(posedge clk);
        late_req++;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bad = bad | mem_req | dm_ready | if_ready;
        end
        chk("t5_quiet_after_late_ack", 64'(bad), 64'd0);
        ack_en = 1'b1;
        drain("t5");

`ifdef ARB_TIMEOUT_EN
        // no ack: abort on the 9th cycle after entering BUSY
        ack_en = 1'b0;
        push_if(32'h0040_0030, 32'hDEAD_BEEF, 1'b1);
        drain("t6");
        chk("t6_timeout_latency", 64'(last_if_ready_cyc - last_grant_cyc), 64'd8);
        // ack in the last BUSY cycle beats the timeout
        ack_en = 1'b1;
        ack_delay = 8;
        push_dm(32'h1001_0050, 1'b0, 1'b0, 32'h0, 32'h0050_1001, 1'b0);
        drain("t7");
        chk("t7_ack_latency", 64'(last_dm_ready_cyc - last_grant_cyc), 64'd8);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
